// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART receive APB controller.
//   - register byte offsets (DATA / STATUS / CTRL)
//   - STATUS and CTRL bit positions
//   - APB phase state encoding
package uart_apb_pkg;

  localparam logic [7:0] DATA_OFS   = 8'h00;
  localparam logic [7:0] STATUS_OFS = 8'h04;
  localparam logic [7:0] CTRL_OFS   = 8'h08;

  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_CNT_LSB = 8;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_FLUSH  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/uart_rx_apb_ctrl_if.sv
// APB bus bundle for uart_rx_apb_ctrl.
//   i_Psel, i_Penable, i_Pwrite, i_Paddr, i_Pwdata : master -> slave
//   o_Prdata, o_Pready, o_Pslverr                  : slave -> master
interface uart_rx_apb_ctrl_if #(
  parameter int unsigned ADDR_W = 4
) ();

  logic              i_Psel;
  logic              i_Penable;
  logic              i_Pwrite;
  logic [ADDR_W-1:0] i_Paddr;
  logic [31:0]       i_Pwdata;
  logic [31:0]       o_Prdata;
  logic              o_Pready;
  logic              o_Pslverr;

  modport master (
    output i_Psel, i_Penable, i_Pwrite, i_Paddr, i_Pwdata,
    input  o_Prdata, o_Pready, o_Pslverr
  );

  modport slave (
    input  i_Psel, i_Penable, i_Pwrite, i_Paddr, i_Pwdata,
    output o_Prdata, o_Pready, o_Pslverr
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Word FIFO for received UART data.
//   i_Clock, i_Reset : clock, synchronous active-high reset
//   push, wr_data    : write wr_data at the tail (caller guarantees space)
//   pop              : advance the head (caller guarantees data)
//   flush            : empty the FIFO
//   head_data        : word at the head
//   full, empty      : occupancy flags
//   count            : words held (wptr - rptr)
module uart_rx_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned PTR_W = AW + 1
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [31:0]      wr_data,
  output logic [31:0]      head_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] count
);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [31:0]      mem [DEPTH];

  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
    end
  end

  assign head_data = mem[rptr[AW-1:0]];
  assign empty     = (wptr == rptr);
  assign full      = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count     = wptr - rptr;

endmodule

// File: rtl/uart_rx_apb_ctrl.sv
// APB slave in front of uart_rx: gates reception with an enable bit, queues
// received words in uart_rx_fifo and exposes DATA / STATUS / CTRL registers.
//   i_Clock, i_Reset     : clock, synchronous active-high reset
//   i_Rx_DV, i_Rx_Word   : word strobe and data from uart_rx
//   apb (slave modport)  : APB bus, zero wait states
//   o_Irq                : level interrupt, only when UART_RX_CTRL_IRQ_EN is defined
module uart_rx_apb_ctrl
  import uart_apb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     i_Rx_DV,
  input  logic [31:0]              i_Rx_Word,
  uart_rx_apb_ctrl_if.slave        apb
`ifdef UART_RX_CTRL_IRQ_EN
  ,
  output logic                     o_Irq
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

  apb_state_e       state;
  logic             enable;
  logic             overflow;
`ifdef UART_RX_CTRL_IRQ_EN
  logic             irq_en;
`endif

  logic [31:0]      head;
  logic             full, empty;
  logic [PTR_W-1:0] fifo_count;

  logic [ADDR_W-1:0] word_addr;
  logic sel_data, sel_status, sel_ctrl, sel_rsvd;
  logic in_access, proto_err, acc_err, wr_ok;
  logic do_pop, do_flush, push_req, do_push, ovf_set;
  logic [31:0] status_word, rd_word;
  logic unused_ok;

  assign word_addr  = {apb.i_Paddr[ADDR_W-1:2], 2'b00};
  assign sel_data   = (word_addr == ADDR_W'(DATA_OFS));
  assign sel_status = (word_addr == ADDR_W'(STATUS_OFS));
  assign sel_ctrl   = (word_addr == ADDR_W'(CTRL_OFS));
  assign sel_rsvd   = !(sel_data || sel_status || sel_ctrl);

  // state holds the phase of the previous bus cycle: after SETUP the current
  // cycle is the access phase, whose closing edge commits the transfer.
  assign in_access = (state == SETUP) && apb.i_Psel && apb.i_Penable;
  assign proto_err = (state != SETUP) && apb.i_Psel && apb.i_Penable;

  assign acc_err = sel_rsvd
                || ( apb.i_Pwrite && sel_data)
                || (!apb.i_Pwrite && sel_data && empty);
  assign wr_ok   = in_access && apb.i_Pwrite && !acc_err;

  assign do_pop   = in_access && !apb.i_Pwrite && sel_data && !empty;
  assign do_flush = wr_ok && sel_ctrl && apb.i_Pwdata[CTRL_FLUSH];
  assign push_req = i_Rx_DV && enable && !do_flush;
  // A pop on the same edge frees the slot the full FIFO needs.
  assign do_push  = push_req && (!full || do_pop);
  assign ovf_set  = push_req && full && !do_pop;

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .push      (do_push),
    .pop       (do_pop),
    .flush     (do_flush),
    .wr_data   (i_Rx_Word),
    .head_data (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_comb begin
    status_word                    = '0;
    status_word[ST_EMPTY]          = empty;
    status_word[ST_FULL]           = full;
    status_word[ST_OVF]            = overflow;
    status_word[ST_CNT_LSB +: 8]   = 8'(fifo_count);
  end

  always_comb begin
    rd_word = '0;
    if (sel_data) begin
      rd_word = head;
    end else if (sel_status) begin
      rd_word = status_word;
    end else if (sel_ctrl) begin
      rd_word[CTRL_EN] = enable;
`ifdef UART_RX_CTRL_IRQ_EN
      rd_word[CTRL_IRQ_EN] = irq_en;
`endif
    end
  end

  always_comb begin
    apb.o_Prdata  = '0;
    apb.o_Pslverr = 1'b0;
    if (!i_Reset) begin
      if (in_access) begin
        apb.o_Pslverr = acc_err;
        if (!apb.i_Pwrite && !acc_err) apb.o_Prdata = rd_word;
      end else if (proto_err) begin
        apb.o_Pslverr = 1'b1;
      end
    end
  end

  assign apb.o_Pready = 1'b1;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state    <= IDLE;
      enable   <= 1'b0;
      overflow <= 1'b0;
`ifdef UART_RX_CTRL_IRQ_EN
      irq_en   <= 1'b0;
      o_Irq    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:    if (apb.i_Psel && !apb.i_Penable) state <= SETUP;
        SETUP:   state <= ACCESS;
        ACCESS:  state <= (apb.i_Psel && !apb.i_Penable) ? SETUP : IDLE;
        default: state <= IDLE;
      endcase

      if (wr_ok && sel_ctrl) begin
        enable <= apb.i_Pwdata[CTRL_EN];
`ifdef UART_RX_CTRL_IRQ_EN
        irq_en <= apb.i_Pwdata[CTRL_IRQ_EN];
`endif
      end

      // A fresh drop outranks a write-1-to-clear on the same edge.
      if (do_flush)
        overflow <= 1'b0;
      else if (ovf_set)
        overflow <= 1'b1;
      else if (wr_ok && sel_status && apb.i_Pwdata[ST_OVF])
        overflow <= 1'b0;

`ifdef UART_RX_CTRL_IRQ_EN
      o_Irq <= irq_en && (!empty || overflow);
`endif
    end
  end

  assign unused_ok = ^{apb.i_Pwdata[31:2], apb.i_Paddr[1:0]};

endmodule

// File: tb/tb_uart_rx_apb_ctrl.sv
module tb_uart_rx_apb_ctrl;

  localparam int unsigned DEPTH = 4;
`ifdef UART_RX_CTRL_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
  logic irq;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [31:0] word;

  always #5 clk = ~clk;

  uart_rx_apb_ctrl_if #(.ADDR_W(4)) apb ();

  uart_rx_apb_ctrl #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
    .i_Clock   (clk),
    .i_Reset   (rst),
    .i_Rx_DV   (dv),
    .i_Rx_Word (word),
    .apb       (apb)
`ifdef UART_RX_CTRL_IRQ_EN
    ,
    .o_Irq     (irq)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of held words plus the architectural bits.
  logic [31:0] q[$];
  logic        m_en    = 1'b0;
  logic        m_ovf   = 1'b0;
  logic        m_irqen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s       = '0;
    s[0]    = (q.size() == 0);
    s[1]    = (q.size() == DEPTH);
    s[2]    = m_ovf;
    s[15:8] = 8'(q.size());
    return s;
  endfunction

  function automatic void m_push(input logic [31:0] w);
    if (q.size() < DEPTH) q.push_back(w);
    else m_ovf = 1'b1;
  endfunction

  task automatic inject(input logic [31:0] w);
    @(posedge clk); #1;
    dv = 1'b1; word = w;
    @(posedge clk); #1;
    dv = 1'b0;
    if (m_en) m_push(w);
  endtask

  // One APB transfer (setup + access), optionally with a word strobe during
  // the access cycle. Checks the response against the model, then advances it.
  task automatic xfer(input string tag, input logic wr, input logic [3:0] addr,
                      input logic [31:0] wdata, input logic rx, input logic [31:0] rxw);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        old_en;
    logic        flush;
    int          idx;
    idx     = int'(addr[3:2]);
    exp_err = (idx == 3) || (wr && idx == 0) || (!wr && idx == 0 && q.size() == 0);
    exp_rd  = '0;
    if (!wr && !exp_err) begin
      case (idx)
        0:       exp_rd = q[0];
        1:       exp_rd = m_status();
        default: exp_rd = {29'd0, m_irqen, 1'b0, m_en};
      endcase
    end
    @(posedge clk); #1;
    apb.i_Psel = 1'b1; apb.i_Penable = 1'b0; apb.i_Pwrite = wr;
    apb.i_Paddr = addr; apb.i_Pwdata = wdata;
    @(posedge clk); #1;
    apb.i_Penable = 1'b1; dv = rx; word = rxw;
    @(negedge clk);
    check({tag, "_slverr"}, 32'(apb.o_Pslverr), 32'(exp_err));
    if (!wr) check({tag, "_rdata"}, apb.o_Prdata, exp_rd);
    @(posedge clk); #1;
    apb.i_Psel = 1'b0; apb.i_Penable = 1'b0; apb.i_Pwrite = 1'b0; dv = 1'b0;
    old_en = m_en;
    flush  = 1'b0;
    if (!exp_err) begin
      if (!wr && idx == 0) void'(q.pop_front());
      if (wr && idx == 1 && wdata[2]) m_ovf = 1'b0;
      if (wr && idx == 2) begin
        m_en    = wdata[0];
        m_irqen = HAS_IRQ ? wdata[2] : 1'b0;
        if (wdata[1]) begin
          flush = 1'b1;
          q.delete();
          m_ovf = 1'b0;
        end
      end
    end
    if (rx && old_en && !flush) m_push(rxw);
  endtask

  initial begin
    int unsigned op;
    logic        rx;
    logic [31:0] rw, wd;
    logic [31:0] last;

    rst = 1'b1; dv = 1'b0; word = '0;
    apb.i_Psel = 1'b0; apb.i_Penable = 1'b0; apb.i_Pwrite = 1'b0;
    apb.i_Paddr = '0; apb.i_Pwdata = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_prdata",  apb.o_Prdata, 32'h0);
    check("rst_pslverr", 32'(apb.o_Pslverr), 32'h0);
    check("rst_pready",  32'(apb.o_Pready), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    xfer("rst_status", 1'b0, 4'h4, '0, 1'b0, '0);
    xfer("rst_ctrl",   1'b0, 4'h8, '0, 1'b0, '0);

    // Basic push / pop
    xfer("en", 1'b1, 4'h8, 32'h1, 1'b0, '0);
    inject(32'hDEADBEEF);
    inject(32'h12345678);
    xfer("two_status", 1'b0, 4'h4, '0, 1'b0, '0);
    xfer("pop1", 1'b0, 4'h0, '0, 1'b0, '0);
    xfer("pop2", 1'b0, 4'h0, '0, 1'b0, '0);
    xfer("pop_empty", 1'b0, 4'h0, '0, 1'b0, '0);

    // Overflow and write-1-to-clear
    for (int i = 0; i < DEPTH + 1; i++) inject($urandom);
    xfer("ovf_status", 1'b0, 4'h4, '0, 1'b0, '0);
    xfer("ovf_w1c", 1'b1, 4'h4, 32'h4, 1'b0, '0);
    xfer("ovf_cleared", 1'b0, 4'h4, '0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) xfer("drain", 1'b0, 4'h0, '0, 1'b0, '0);

    // Full FIFO with pop and push on the same edge
    for (int i = 0; i < DEPTH; i++) inject($urandom);
    last = $urandom;
    xfer("full_pop_push", 1'b0, 4'h0, '0, 1'b1, last);
    xfer("full_pp_status", 1'b0, 4'h4, '0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) xfer("drain2", 1'b0, 4'h0, '0, 1'b0, '0);
    check("last_out_model", q.size(), 0);

    // Disabled receive, then flush with a concurrent push
    xfer("dis", 1'b1, 4'h8, 32'h0, 1'b0, '0);
    inject(32'hA5A5A5A5);
    xfer("dis_status", 1'b0, 4'h4, '0, 1'b0, '0);
    xfer("en2", 1'b1, 4'h8, 32'h1, 1'b0, '0);
    inject($urandom);
    inject($urandom);
    xfer("flush", 1'b1, 4'h8, 32'h3, 1'b1, $urandom);
    xfer("flush_status", 1'b0, 4'h4, '0, 1'b0, '0);
    xfer("flush_ctrl", 1'b0, 4'h8, '0, 1'b0, '0);

    // Error accesses leave state untouched
    inject(32'hCAFEF00D);
    xfer("wr_data", 1'b1, 4'h0, 32'hFFFFFFFF, 1'b0, '0);
    xfer("rd_rsvd", 1'b0, 4'hC, '0, 1'b0, '0);
    xfer("wr_rsvd", 1'b1, 4'hC, 32'hFFFFFFFF, 1'b0, '0);
    xfer("err_status", 1'b0, 4'h4, '0, 1'b0, '0);

    // Penable without a preceding setup
    @(posedge clk); #1;
    apb.i_Psel = 1'b1; apb.i_Penable = 1'b1; apb.i_Pwrite = 1'b0; apb.i_Paddr = 4'h0;
    @(negedge clk);
    check("proto_slverr", 32'(apb.o_Pslverr), 32'h1);
    check("proto_rdata",  apb.o_Prdata, 32'h0);
    @(posedge clk); #1;
    apb.i_Psel = 1'b0; apb.i_Penable = 1'b0;
    xfer("proto_status", 1'b0, 4'h4, '0, 1'b0, '0);

    // Randomized mix against the model
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 9);
      rx = ($urandom_range(0, 3) == 0);
      rw = $urandom;
      case (op)
        0, 1, 2: inject(rw);
        3, 4, 5: xfer("r_data", 1'b0, {2'd0, 2'($urandom)}, '0, rx, rw);
        6:       xfer("r_status", 1'b0, {2'd1, 2'($urandom)}, '0, rx, rw);
        7:       xfer("w_status", 1'b1, {2'd1, 2'($urandom)}, $urandom, rx, rw);
        8: begin
          wd    = $urandom;
          wd[0] = ($urandom_range(0, 4) != 0);
          wd[1] = ($urandom_range(0, 7) == 0);
          xfer("w_ctrl", 1'b1, {2'd2, 2'($urandom)}, wd, rx, rw);
          xfer("r_ctrl", 1'b0, 4'h8, '0, 1'b0, '0);
        end
        default: xfer("rsvd", 1'($urandom), {2'd3, 2'($urandom)}, $urandom, rx, rw);
      endcase
    end
    xfer("rand_status", 1'b0, 4'h4, '0, 1'b0, '0);

    // Reset during an access phase with a word arriving
    xfer("en3", 1'b1, 4'h8, 32'h1, 1'b0, '0);
    inject($urandom);
    @(posedge clk); #1;
    apb.i_Psel = 1'b1; apb.i_Penable = 1'b0; apb.i_Pwrite = 1'b0; apb.i_Paddr = 4'h0;
    @(posedge clk); #1;
    apb.i_Penable = 1'b1; rst = 1'b1; dv = 1'b1; word = $urandom;
    @(negedge clk);
    check("midrst_slverr", 32'(apb.o_Pslverr), 32'h0);
    check("midrst_rdata",  apb.o_Prdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; dv = 1'b0; apb.i_Psel = 1'b0; apb.i_Penable = 1'b0;
    q.delete(); m_en = 1'b0; m_ovf = 1'b0; m_irqen = 1'b0;
    xfer("midrst_status", 1'b0, 4'h4, '0, 1'b0, '0);
    xfer("midrst_ctrl",   1'b0, 4'h8, '0, 1'b0, '0);

`ifdef UART_RX_CTRL_IRQ_EN
    xfer("irq_ctrl", 1'b1, 4'h8, 32'h7, 1'b0, '0);
    @(posedge clk); #1;
    check("irq_idle", 32'(irq), 32'h0);
    inject($urandom);
    @(posedge clk); #1;
    check("irq_set", 32'(irq), 32'h1);
    xfer("irq_pop", 1'b0, 4'h0, '0, 1'b0, '0);
    @(posedge clk); #1;
    check("irq_clr", 32'(irq), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_apb_ctrl.md
# uart_rx_apb_ctrl

APB slave controller that sits between `uart_rx` and the system APB bus. It gates the receiver with an enable bit and captures each 32-bit word on `i_Rx_DV` into a small FIFO. It exposes data, status and control registers to the bus master, so software drains words at its own pace instead of sampling `o_Rx_Byte` directly.

## Interface
- `DEPTH`, default 4: FIFO depth in 32-bit words; power of two, minimum 2.
- `ADDR_W`, default 4: width of `i_Paddr`.
- `i_Clock`, in, 1: system clock, shared with `uart_rx`.
- `i_Reset`, in, 1: synchronous, active-high reset.
- `i_Rx_DV`, in, 1: one-cycle word-valid strobe from `uart_rx`.
- `i_Rx_Word`, in, 32: received word; valid while `i_Rx_DV`=1.
- `i_Psel`, `i_Penable`, `i_Pwrite`, in, 1 each: APB control.
- `i_Paddr`, in, `ADDR_W`: byte address; bits [1:0] are ignored.
- `i_Pwdata`, in, 32: APB write data.
- `o_Prdata`, out, 32: APB read data.
- `o_Pready`, out, 1: tied to 1; accesses have zero wait states.
- `o_Pslverr`, out, 1: APB error response.
- `o_Irq`, out, 1: level interrupt; present only with `UART_RX_CTRL_IRQ_EN`.

## Operation
- Register map:
  - 0x0 DATA (RO): a read pops the FIFO head.
  - 0x4 STATUS: bit0 empty, bit1 full, bit2 overflow (sticky, write-1-to-clear), bits[15:8] count. All other bits read 0.
  - 0x8 CTRL (RW): bit0 enable (reset 0), bit1 flush (self-clearing, reads 0), bit2 irq_en (reset 0).
  - 0xC: reserved.
- Push rule:
  - When `i_Rx_DV`=1 and enable=1 and the FIFO is not full, write `i_Rx_Word` at the tail.
  - When enable=0, the word is dropped silently and overflow is not set.
- Full rule: on push while full, drop the word and set overflow. Exception: if a DATA pop completes in the same cycle, the push proceeds and overflow stays 0.
- Pop rule:
  - A DATA read in the access phase with the FIFO non-empty returns the head word and advances the head at that clock edge.
  - A DATA read while empty returns 0 with `o_Pslverr`=1.
- Other error responses (`o_Pslverr`=1): any write to DATA or to 0xC, and any read of 0xC. Reads of 0xC return 0. No register changes on an error access.
- Flush:
  - Writing CTRL bit1=1 empties the FIFO and clears overflow in that cycle.
  - The rest of the CTRL write (enable, irq_en) takes effect in the same cycle.
  - A push in the same cycle is discarded.
- APB phase FSM, states IDLE, SETUP, ACCESS:
  - IDLE→SETUP on `i_Psel`=1 with `i_Penable`=0.
  - SETUP→ACCESS unconditionally.
  - ACCESS→SETUP if `i_Psel`=1 with `i_Penable`=0; otherwise ACCESS→IDLE.
  - `i_Penable`=1 seen outside ACCESS is a protocol error: respond `o_Pslverr`=1 and take no register or FIFO action.
- Pointers:
  - Read and write pointers are log2(`DEPTH`)+1 bits wide and wrap naturally.
  - full = MSBs differ and low bits equal; empty = pointers equal.
  - count = wptr − rptr, zero-extended to 8 bits.

## Timing
- Reset values:
  - `o_Prdata`=0, `o_Pslverr`=0, `o_Irq`=0, `o_Pready`=1.
  - FIFO empty, overflow=0, CTRL=0, FSM=IDLE.
- Reset mid-transfer: the FSM returns to IDLE, a word arriving in the reset cycle is lost, and the in-flight APB access is ignored.
- `o_Prdata` and `o_Pslverr` are combinational during ACCESS and 0 in every other state.
- Register and FIFO updates happen on the `i_Clock` edge that ends ACCESS.
- Push-to-visible latency: a word pushed on edge N is readable and reflected in STATUS from cycle N+1.
- Throughput: one push and one pop may complete per cycle.

## Configuration
- `UART_RX_CTRL_IRQ_EN` defined:
  - `o_Irq` port exists and is registered.
  - `o_Irq` = irq_en & (!empty | overflow), updated one cycle after the causing event.
- `UART_RX_CTRL_IRQ_EN` undefined:
  - `o_Irq` port is absent.
  - CTRL bit2 reads 0 and ignores writes; all other behaviour is identical.

## Structure
- Shared package `uart_apb_pkg` holds:
  - the register offset constants (`DATA_OFS`, `STATUS_OFS`, `CTRL_OFS`);
  - the STATUS and CTRL bit-position constants;
  - the APB phase state encoding (IDLE/SETUP/ACCESS).
- One sub-module, `uart_rx_fifo`:
  - parameterised by `DEPTH`; synchronous active-high reset;
  - ports: push, pop, flush, write data, head data, full, empty, count.
- The top level holds the APB FSM, register decode, overflow/enable logic and IRQ.

## Test plan
- Reset, then read STATUS → 0x0000_0001 (empty). Read CTRL → 0. `o_Pslverr`=0.
- Enable; inject 0xDEADBEEF then 0x12345678 on `i_Rx_DV`. STATUS count=2. DATA reads return 0xDEADBEEF then 0x12345678. A third DATA read → 0 with `o_Pslverr`=1.
- Inject `DEPTH`+1 words with no reads → STATUS full=1, overflow=1, count=`DEPTH`. Write STATUS 0x4 → overflow=0. Drained data equals the first `DEPTH` words in order.
- FIFO full: pop DATA in the same cycle as `i_Rx_DV` → overflow stays 0, count unchanged, and the new word is last out.
- Enable=0: inject 0xA5A5A5A5 → count=0, overflow=0. Write CTRL 0x3 with 2 words queued → count=0 the next cycle and enable=1.
- With `UART_RX_CTRL_IRQ_EN`: irq_en=1, push one word → `o_Irq`=1 one cycle later. Pop it → `o_Irq`=0 one cycle after the pop.
